ecg_fir_tdm: RTL and testbench

- Parametrised successor to the fixed two-stage FIR chain. A single time-multiplexed MAC filters up to CHANNELS independent ECG leads.
- Each lead has its own circular delay line. Coefficients are held in a runtime-writable table instead of constants.
- Valid/ready handshakes on input and output let the block sit between the UART/ADC sample front end and downstream analysis logic.
- Rounding and output narrowing are explicit.

---
 rtl/ecg_fir_tdm.sv | 158 +++++++++++++++
 tb/tb_ecg_fir_tdm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ecg_fir_tdm.sv
// Time-multiplexed FIR: one MAC serves CHANNELS leads, each with its own circular delay line; runtime-writable taps.
// Latency ORDER+1 cycles from accept to OutValid; InReady low while busy. Define FIR_SAT_EN to saturate instead of wrap.
module ecg_fir_tdm #(
  parameter int DATAWIDTH      = 16,
  parameter int COEFFDATAWIDTH = 16,
  parameter int ORDER          = 41,
  parameter int CHANNELS       = 4,
  parameter int FRAC_BITS      = 15,
  parameter int CHW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int ACCWIDTH       = DATAWIDTH + COEFFDATAWIDTH + $clog2(ORDER)
) (
  input  logic                             Clk,
  input  logic                             nRst,
  input  logic                             InValid,
  output logic                             InReady,
  input  logic signed [DATAWIDTH-1:0]      InData,
  input  logic [CHW-1:0]                   InChan,
  output logic                             OutValid,
  input  logic                             OutReady,
  output logic signed [DATAWIDTH-1:0]      OutData,
  output logic [CHW-1:0]                   OutChan,
  input  logic                             CoefWe,
  input  logic [$clog2(ORDER)-1:0]         CoefAddr,
  input  logic signed [COEFFDATAWIDTH-1:0] CoefData,
  output logic                             Busy
);

  localparam int AW = $clog2(ORDER);
  localparam int PW = DATAWIDTH + COEFFDATAWIDTH;
  localparam logic [AW-1:0] ORDER_A  = AW'(ORDER);
  localparam logic [AW-1:0] LAST_TAP = AW'(ORDER - 1);
  localparam logic signed [ACCWIDTH-1:0] RND_HALF = ACCWIDTH'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACCWIDTH-1:0] SAT_MAX  = {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [ACCWIDTH-1:0] SAT_MIN  = {{(ACCWIDTH-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [CHW-1:0]                  chan_q, chan_d;
  logic [AW-1:0]                   k_q, k_d;
  logic signed [ACCWIDTH-1:0]      acc_q, acc_d;
  logic                            out_vld_q, out_vld_d;
  logic signed [DATAWIDTH-1:0]     out_dat_q, out_dat_d;
  logic [CHW-1:0]                  out_chan_q, out_chan_d;
  logic [AW-1:0]                   head_q [CHANNELS];
  logic signed [DATAWIDTH-1:0]     x_q    [CHANNELS][ORDER];
  logic signed [COEFFDATAWIDTH-1:0] coef_q [ORDER];

  logic                        accept, chan_ok, coef_wr;
  logic [AW-1:0]               head_cur, tap_idx;
  logic signed [PW-1:0]        prod;
  logic signed [ACCWIDTH-1:0]  acc_rnd, r;
  logic signed [DATAWIDTH-1:0] r_nar;

  assign chan_ok  = int'(InChan) < CHANNELS;
  assign accept   = (state_q == S_IDLE) && InValid;
  assign coef_wr  = (state_q == S_IDLE) && CoefWe && (int'(CoefAddr) < ORDER);

  // (head - k) mod ORDER, done modulo 2^AW so ORDER == 2^AW needs no special case
  assign head_cur = head_q[chan_q];
  assign tap_idx  = head_cur - k_q + ((head_cur < k_q) ? ORDER_A : '0);
  assign prod     = x_q[chan_q][tap_idx] * coef_q[k_q];

  assign acc_rnd  = acc_q + RND_HALF;
  assign r        = acc_rnd >>> FRAC_BITS;

`ifdef FIR_SAT_EN
  always_comb begin
    r_nar = r[DATAWIDTH-1:0];
    if (r > SAT_MAX)      r_nar = SAT_MAX[DATAWIDTH-1:0];
    else if (r < SAT_MIN) r_nar = SAT_MIN[DATAWIDTH-1:0];
  end
`else
  logic unused_rnd_hi;
  assign r_nar         = r[DATAWIDTH-1:0];
  assign unused_rnd_hi = ^{r[ACCWIDTH-1:DATAWIDTH], SAT_MAX, SAT_MIN};
`endif

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    k_d        = k_q;
    acc_d      = acc_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_chan_d = out_chan_q;
    case (state_q)
      S_IDLE: if (accept && chan_ok) begin
        state_d = S_MAC;
        chan_d  = InChan;
        k_d     = '0;
        acc_d   = '0;
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACCWIDTH-PW){prod[PW-1]}}, prod};
        k_d   = k_q + AW'(1);
        if (k_q == LAST_TAP) state_d = S_ROUND;
      end
      S_ROUND: begin
        out_dat_d  = r_nar;
        out_chan_d = chan_q;
        out_vld_d  = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: if (OutReady) begin
        out_vld_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_chan_q <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_chan_q <= out_chan_d;
    end
  end

  // Sample storage, head pointers and coefficient table; out-of-range channels never touch state
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      for (int t = 0; t < ORDER; t++) coef_q[t] <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        head_q[c] <= '0;
        for (int t = 0; t < ORDER; t++) x_q[c][t] <= '0;
      end
    end else begin
      if (coef_wr) coef_q[CoefAddr] <= CoefData;
      if (accept && chan_ok) x_q[InChan][head_q[InChan]] <= InData;
      if (state_q == S_ROUND)
        head_q[chan_q] <= (head_q[chan_q] == LAST_TAP) ? '0 : head_q[chan_q] + AW'(1);
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign Busy     = (state_q != S_IDLE);
  assign OutValid = out_vld_q;
  assign OutData  = out_dat_q;
  assign OutChan  = out_chan_q;

endmodule

// File: tb/tb_ecg_fir_tdm.sv
// Directed bench for ecg_fir_tdm: vector table plus backpressure, mid-MAC reset and bad-channel sequences.
// Built with CHANNELS=3 so that an out-of-range channel index fits in the 2-bit InChan.
module tb_ecg_fir_tdm;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int ORDER = 41;
  localparam int CHANNELS = 3;
  localparam int CHW = 2;
  localparam int AW = 6;

  logic                 clk = 1'b0;
  logic                 nRst = 1'b0;
  logic                 InValid = 1'b0;
  logic                 InReady;
  logic signed [DW-1:0] InData = '0;
  logic [CHW-1:0]       InChan = '0;
  logic                 OutValid;
  logic                 OutReady = 1'b1;
  logic signed [DW-1:0] OutData;
  logic [CHW-1:0]       OutChan;
  logic                 CoefWe = 1'b0;
  logic [AW-1:0]        CoefAddr = '0;
  logic signed [CW-1:0] CoefData = '0;
  logic                 Busy;

  ecg_fir_tdm #(.DATAWIDTH(DW), .COEFFDATAWIDTH(CW), .ORDER(ORDER), .CHANNELS(CHANNELS),
                .FRAC_BITS(15)) dut (
    .Clk(clk), .nRst(nRst), .InValid(InValid), .InReady(InReady), .InData(InData),
    .InChan(InChan), .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutChan(OutChan), .CoefWe(CoefWe), .CoefAddr(CoefAddr), .CoefData(CoefData), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit rst;
    int c0;
    int c1;
    int chan;
    int din;
    int exp_dat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b0; InValid = 1'b0; CoefWe = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    CoefWe = 1'b1; CoefAddr = AW'(addr); CoefData = CW'(val);
    @(negedge clk);
    CoefWe = 1'b0;
  endtask

  task automatic send(input int chan, input int din);
    @(negedge clk);
    InValid = 1'b1; InChan = CHW'(chan); InData = DW'(din);
    @(posedge clk);
    #1 InValid = 1'b0;
  endtask

  // Counts edges after the accept edge until OutValid is seen
  task automatic wait_out(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    while (lat < 200 && !ok) begin
      @(posedge clk);
      lat++;
      #1 if (OutValid) ok = 1'b1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  ok;
    int  seen;

    vecs[0] = '{1'b1, 16384, 0,     0, 1000,   500};
    vecs[1] = '{1'b0, 16384, 0,     0, 3,      2};
    vecs[2] = '{1'b0, 16384, 0,     0, -3,     -1};
    vecs[3] = '{1'b1, 16384, 8192,  0, 2000,   1000};
    vecs[4] = '{1'b0, 16384, 8192,  1, 4000,   2000};
    vecs[5] = '{1'b0, 16384, 8192,  0, 0,      500};
    vecs[6] = '{1'b0, 16384, 8192,  1, 0,      1000};
    vecs[7] = '{1'b1, 32767, 32767, 2, 32767,  32766};
`ifdef FIR_SAT_EN
    vecs[8] = '{1'b0, 32767, 32767, 2, 32767,  32767};
`else
    vecs[8] = '{1'b0, 32767, 32767, 2, 32767,  -4};
`endif

    #2;
    check("rst_inready",  int'(InReady),  1);
    check("rst_outvalid", int'(OutValid), 0);
    check("rst_outdata",  int'(OutData),  0);
    check("rst_outchan",  int'(OutChan),  0);
    check("rst_busy",     int'(Busy),     0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        write_coef(0, vecs[i].c0);
        write_coef(1, vecs[i].c1);
      end
      send(vecs[i].chan, vecs[i].din);
      check($sformatf("v%0d_busy", i), int'(Busy), 1);
      wait_out(lat, ok);
      check($sformatf("v%0d_timeout", i), int'(ok), 1);
      if (i == 0) check("v0_latency", lat, ORDER + 1);
      check($sformatf("v%0d_data", i), int'(OutData), vecs[i].exp_dat);
      check($sformatf("v%0d_chan", i), int'(OutChan), vecs[i].chan);
      @(posedge clk);
    end

    // Backpressure with coefficient writes attempted while busy
    do_reset();
    write_coef(0, 16384);
    OutReady = 1'b0;
    send(1, 1000);
    wait_out(lat, ok);
    check("bp_timeout", int'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      CoefWe = (i % 2 == 0); CoefAddr = '0; CoefData = '0;
      check($sformatf("bp_hold%0d", i),
            int'(OutValid && !InReady && OutData == 16'sd500 && OutChan == 2'd1), 1);
    end
    @(negedge clk);
    CoefWe = 1'b0;
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    check("bp_outvalid_drop", int'(OutValid), 0);
    check("bp_inready_back",  int'(InReady),  1);
    send(0, 1000);
    wait_out(lat, ok);
    check("bp_coef_kept", int'(OutData), 500);
    @(posedge clk);

    // Reset in the middle of the MAC sweep
    do_reset();
    write_coef(0, 16384);
    send(0, 1000);
    repeat (5) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(Busy), 0);
    nRst = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (OutValid) seen++;
    end
    check("midrst_no_output", seen, 0);
    send(0, 1000);
    wait_out(lat, ok);
    check("midrst_timeout", int'(ok), 1);
    check("midrst_zeroed", int'(OutData), 0);
    @(posedge clk);

    // Out-of-range channel is consumed and dropped
    write_coef(0, 16384);
    send(3, 1000);
    check("badch_idle",  int'(Busy),    0);
    check("badch_ready", int'(InReady), 1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (OutValid) seen++;
    end
    check("badch_no_output", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
